counter_display_driver: RTL and testbench
=========================================

Name: counter_display_driver

Overview:
Downstream consumer of the 4-bit up/down counter value. Drives a 4-digit, common-anode, time-multiplexed seven-segment display:
- digit0: ones; digit1: tens of the counter value 0..15.
- digit2: blank.
- digit3: direction glyph, 'U' or 'd'.
Inputs are sampled once per scan frame to avoid tearing. The digit0 decimal point flashes for a set number of frames after each value change.

Parameters:
SCAN_DIV, 100000, clocks per digit slot; must be ≥ 2 and > BLANK_CYC.
BLANK_CYC, 16, clocks at the start of each slot with all anodes off (ghosting guard).
FLASH_FRAMES, 50, frames the change-indicator DP stays lit after a value change; 0 disables it.
LEADING_BLANK, 1, 1 = tens digit blank when value < 10; 0 = shows '0'.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
value  input  4  counter value to display, unsigned 0..15
up_dn  input  1  count direction: 1 = up, 0 = down
an  output  4  digit anodes, active low, an[k] = digit k
seg  output  7  segments {g,f,e,d,c,b,a}, active low
dp  output  1  decimal point, active low

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values:
  - an=4'b1111, seg=7'h7F, dp=1.
  - Internal: scan_cnt=0, slot=0, shadow_val=0, shadow_dir=0, flash_cnt=0.
- Scan timing:
  - scan_cnt counts 0..SCAN_DIV-1, then wraps to 0.
  - On wrap, slot advances 0→1→2→3→0. One frame = 4*SCAN_DIV clocks.
- Frame boundary: the clock where scan_cnt==SCAN_DIV-1 and slot==3. On that edge:
  - shadow_val<=value and shadow_dir<=up_dn.
  - If value!=shadow_val: flash_cnt<=FLASH_FRAMES (reload wins over decrement).
  - Else, if flash_cnt!=0: flash_cnt decrements.
  - value/up_dn changes at any other time have no visible effect until the next boundary.
- Outputs are registered. an/seg/dp reflect the current (scan_cnt, slot) with 1-clock latency.
- Anodes:
  - an=4'b1111 while scan_cnt < BLANK_CYC.
  - Otherwise an = ~(1<<slot).
  - seg and dp are driven to the slot's pattern for the whole slot, including the blank window.
- Digit content:
  - ones = shadow_val≥10 ? shadow_val-10 : shadow_val.
  - tens = 1 if shadow_val≥10; otherwise blank (LEADING_BLANK=1) or '0'.
  - slot2 = blank.
  - slot3 = shadow_dir ? 'U' : 'd'.
- Encoding (gfedcba, active low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - U=41, d=21, blank=7F.
- dp=0 only when slot==0 and flash_cnt!=0; otherwise dp=1.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous). Scanning restarts from slot0 on the first clock after release.
- No arithmetic overflow: value is 4 bits, so the maximum display is "15".

Test Plan:
(All scenarios use SCAN_DIV=8, BLANK_CYC=2, FLASH_FRAMES=2, LEADING_BLANK=1.)
1. Reset, hold value=0, up_dn=0 → an=1111/seg=7F/dp=1 during reset. After release:
   - slot0 shows seg=40 with an=1110 from cycle 3 to cycle 8.
   - Slots 1/2 show seg=7F; slot3 shows seg=21.
   - an=1111 for 2 cycles at each slot start.
2. value=13, up_dn=1 applied mid-frame → the current frame still shows 0/'d'. The next frame shows:
   - an=1110 seg=30 (3); an=1101 seg=79 (1); an=1011 seg=7F; an=0111 seg=41 (U).
3. Change 13→13 across a boundary → dp stays 1. Change 13→7 → dp=0 during slot0 for exactly 2 frames, then dp=1; tens slot shows 7F.
4. value changes at two consecutive boundaries (5 then 6) → flash_cnt reloads to 2 at the second change. dp stays low in slot0 for 2 frames after the second change.
5. Assert rst_n low mid-slot2 with value=15 → outputs immediately 1111/7F/1. After release the display shows value captured at the first boundary; shadow reads 0 until then.
6. Sweep value 0..15, one value per frame → each ones/tens pattern matches the encoding table. LEADING_BLANK=0 rerun: tens shows seg=40 for values 0..9.

Source files
------------

// File: rtl/counter_display_driver.sv
// Four-digit common-anode seven-segment driver for a 4-bit up/down counter.
// Inputs are captured once per scan frame; the ones-digit DP flashes after each value change.
module counter_display_driver #(
    parameter int SCAN_DIV      = 100000,
    parameter int BLANK_CYC     = 16,
    parameter int FLASH_FRAMES  = 50,
    parameter int LEADING_BLANK = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] value,
    input  logic       up_dn,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (FLASH_FRAMES > 0) ? $clog2(FLASH_FRAMES + 1) : 1;
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] BLANK_END  = SW'(BLANK_CYC);
    localparam logic [FW-1:0] FLASH_LOAD = FW'(FLASH_FRAMES);

    localparam logic [6:0] GLYPH_U     = 7'h41;
    localparam logic [6:0] GLYPH_D     = 7'h21;
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;

    logic [SW-1:0] scan_cnt;
    logic [1:0]    slot;
    logic [3:0]    shadow_val;
    logic          shadow_dir;
    logic [FW-1:0] flash_cnt;
    logic          frame_end;

    logic [3:0]    ones;
    logic [3:0]    an_p0;
    logic [6:0]    seg_p0;
    logic          dp_p0;

    // Active-low gfedcba pattern for a decimal digit.
    function automatic logic [6:0] digit_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = GLYPH_BLANK;
        endcase
        return s;
    endfunction

    assign frame_end = (scan_cnt == SCAN_LAST) && (slot == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            slot     <= 2'd0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            slot     <= slot + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // A fresh value reloads the flash counter even if it is still running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_val <= 4'd0;
            shadow_dir <= 1'b0;
            flash_cnt  <= '0;
        end else if (frame_end) begin
            shadow_val <= value;
            shadow_dir <= up_dn;
            if (value != shadow_val)
                flash_cnt <= FLASH_LOAD;
            else if (flash_cnt != '0)
                flash_cnt <= flash_cnt - 1'b1;
        end
    end

    always_comb begin
        ones   = (shadow_val >= 4'd10) ? (shadow_val - 4'd10) : shadow_val;
        an_p0  = (scan_cnt < BLANK_END) ? 4'b1111 : ~(4'b0001 << slot);
        dp_p0  = !((slot == 2'd0) && (flash_cnt != '0));
        seg_p0 = GLYPH_BLANK;
        case (slot)
            2'd0: seg_p0 = digit_seg(ones);
            2'd1: begin
                if (shadow_val >= 4'd10)
                    seg_p0 = digit_seg(4'd1);
                else if (LEADING_BLANK == 0)
                    seg_p0 = digit_seg(4'd0);
                else
                    seg_p0 = GLYPH_BLANK;
            end
            2'd2: seg_p0 = GLYPH_BLANK;
            2'd3: seg_p0 = shadow_dir ? GLYPH_U : GLYPH_D;
            default: seg_p0 = GLYPH_BLANK;
        endcase
    end

    // p0 -> output register: one clock of latency from scan position to pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= 4'b1111;
            seg <= GLYPH_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= an_p0;
            seg <= seg_p0;
            dp  <= dp_p0;
        end
    end

endmodule

// File: tb/tb_counter_display_driver.sv
// Scoreboard bench: stimulus queues hand-computed display states per cycle, a monitor compares them.
`timescale 1ns/100ps
module tb_counter_display_driver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] value = 4'd0;
    logic       up_dn = 1'b0;
    logic [3:0] an0, an1;
    logic [6:0] seg0, seg1;
    logic       dp0, dp1;

    int cyc = 0;
    int total = 0;
    int passed = 0;

    typedef struct {
        int         cyc;
        string      name;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        bit         lb0;
    } exp_t;

    exp_t q[$];

    logic [6:0] ones_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12};

    counter_display_driver #(.SCAN_DIV(8), .BLANK_CYC(2), .FLASH_FRAMES(2), .LEADING_BLANK(1)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .up_dn(up_dn),
        .an(an0), .seg(seg0), .dp(dp0)
    );

    counter_display_driver #(.SCAN_DIV(8), .BLANK_CYC(2), .FLASH_FRAMES(2), .LEADING_BLANK(0)) dut_lb0 (
        .clk(clk), .rst_n(rst_n), .value(value), .up_dn(up_dn),
        .an(an1), .seg(seg1), .dp(dp1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void exp_at(input int c, input string nm, input logic [3:0] a,
                                   input logic [6:0] s, input logic d, input bit lb0 = 1'b0);
        exp_t e;
        e.cyc = c; e.name = nm; e.an = a; e.seg = s; e.dp = d; e.lb0 = lb0;
        q.push_back(e);
    endfunction

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Monitor: samples 1 ns after each rising edge and retires every entry due this cycle.
    initial begin
        exp_t e;
        logic [3:0] a;
        logic [6:0] s;
        logic       d;
        forever begin
            @(posedge clk);
            #1;
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                total++;
                if (e.cyc < cyc) begin
                    $display("FAIL %s: check for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
                end else begin
                    a = e.lb0 ? an1 : an0;
                    s = e.lb0 ? seg1 : seg0;
                    d = e.lb0 ? dp1 : dp0;
                    if (a === e.an && s === e.seg && d === e.dp)
                        passed++;
                    else
                        $display("FAIL %s @%0d: got an=%b seg=%h dp=%b, want an=%b seg=%h dp=%b",
                                 e.name, cyc, a, s, d, e.an, e.seg, e.dp);
                end
            end
        end
    end

    initial begin
        int b1;
        int b2;
        int last;
        #1 rst_n = 1'b0;
        exp_at(2, "in_reset", 4'b1111, 7'h7F, 1'b1);
        wait_cyc(4);
        rst_n = 1'b1;
        b1 = cyc;

        // Frame 0 after release: 0 / blank / blank / 'd'
        exp_at(b1 + 1,  "f0_s0_blank",  4'b1111, 7'h40, 1'b1);
        exp_at(b1 + 3,  "f0_s0_first",  4'b1110, 7'h40, 1'b1);
        exp_at(b1 + 8,  "f0_s0_last",   4'b1110, 7'h40, 1'b1);
        exp_at(b1 + 9,  "f0_s1_blank",  4'b1111, 7'h7F, 1'b1);
        exp_at(b1 + 11, "f0_tens",      4'b1101, 7'h7F, 1'b1);
        exp_at(b1 + 11, "f0_tens_lb0",  4'b1101, 7'h40, 1'b1, 1'b1);
        exp_at(b1 + 19, "f0_s2",        4'b1011, 7'h7F, 1'b1);
        exp_at(b1 + 25, "f0_s3_blank",  4'b1111, 7'h21, 1'b1);
        exp_at(b1 + 27, "f0_dir",       4'b0111, 7'h21, 1'b1);
        exp_at(b1 + 32, "f0_s3_last",   4'b0111, 7'h21, 1'b1);

        // 13/up applied mid-frame 1; visible from frame 2
        wait_cyc(b1 + 40);
        value = 4'd13;
        up_dn = 1'b1;
        exp_at(b1 + 43,  "f1_tens_held", 4'b1101, 7'h7F, 1'b1);
        exp_at(b1 + 59,  "f1_dir_held",  4'b0111, 7'h21, 1'b1);
        exp_at(b1 + 67,  "f2_ones_13",   4'b1110, 7'h30, 1'b0);
        exp_at(b1 + 75,  "f2_tens_13",   4'b1101, 7'h79, 1'b1);
        exp_at(b1 + 83,  "f2_blank",     4'b1011, 7'h7F, 1'b1);
        exp_at(b1 + 91,  "f2_dir_U",     4'b0111, 7'h41, 1'b1);
        exp_at(b1 + 99,  "f3_flash_2nd", 4'b1110, 7'h30, 1'b0);
        exp_at(b1 + 131, "f4_flash_off", 4'b1110, 7'h30, 1'b1);

        // 13 -> 7
        wait_cyc(b1 + 140);
        value = 4'd7;
        exp_at(b1 + 161, "f5_dp_in_blank", 4'b1111, 7'h78, 1'b0);
        exp_at(b1 + 163, "f5_ones_7",      4'b1110, 7'h78, 1'b0);
        exp_at(b1 + 171, "f5_tens_blank",  4'b1101, 7'h7F, 1'b1);
        exp_at(b1 + 195, "f6_flash_2nd",   4'b1110, 7'h78, 1'b0);
        exp_at(b1 + 227, "f7_flash_off",   4'b1110, 7'h78, 1'b1);

        // Back-to-back changes 5 then 6: second change reloads the flash
        wait_cyc(b1 + 230);
        value = 4'd5;
        exp_at(b1 + 259, "f8_ones_5", 4'b1110, 7'h12, 1'b0);
        wait_cyc(b1 + 260);
        value = 4'd6;
        exp_at(b1 + 291, "f9_ones_6",    4'b1110, 7'h02, 1'b0);
        exp_at(b1 + 323, "f10_reloaded", 4'b1110, 7'h02, 1'b0);
        exp_at(b1 + 355, "f11_flash_off", 4'b1110, 7'h02, 1'b1);

        // 15 shown in frame 12, then reset mid-slot2
        wait_cyc(b1 + 360);
        value = 4'd15;
        exp_at(b1 + 387, "f12_ones_15", 4'b1110, 7'h12, 1'b0);
        exp_at(b1 + 395, "f12_tens_15", 4'b1101, 7'h79, 1'b1);
        exp_at(b1 + 403, "async_reset", 4'b1111, 7'h7F, 1'b1);
        exp_at(b1 + 405, "reset_hold",  4'b1111, 7'h7F, 1'b1);
        wait_cyc(b1 + 402);
        @(posedge clk);
        #0.5 rst_n = 1'b0;
        wait_cyc(b1 + 407);
        rst_n = 1'b1;
        b2 = cyc;

        exp_at(b2 + 3,  "rst_shadow_0",   4'b1110, 7'h40, 1'b1);
        exp_at(b2 + 27, "rst_shadow_dir", 4'b0111, 7'h21, 1'b1);
        exp_at(b2 + 35, "rst_ones_15",    4'b1110, 7'h12, 1'b0);
        exp_at(b2 + 43, "rst_tens_15",    4'b1101, 7'h79, 1'b1);
        exp_at(b2 + 59, "rst_dir_U",      4'b0111, 7'h41, 1'b1);

        // Sweep 0..15, one value per frame, both tens-blanking variants
        for (int i = 0; i < 16; i++) begin
            wait_cyc(b2 + 32 * (2 + i) + 4);
            value = 4'(i);
            exp_at(b2 + 32 * (3 + i) + 3,  $sformatf("sweep_ones_%0d", i), 4'b1110, ones_tab[i], 1'b0);
            exp_at(b2 + 32 * (3 + i) + 11, $sformatf("sweep_tens_%0d", i), 4'b1101,
                   (i >= 10) ? 7'h79 : 7'h7F, 1'b1);
            exp_at(b2 + 32 * (3 + i) + 11, $sformatf("sweep_tens_lb0_%0d", i), 4'b1101,
                   (i >= 10) ? 7'h79 : 7'h40, 1'b1, 1'b1);
        end

        last = b2 + 32 * 18 + 11;
        wait_cyc(last + 3);
        while (q.size() > 0) begin
            total++;
            $display("FAIL %s: check for cycle %0d never retired", q[0].name, q[0].cyc);
            void'(q.pop_front());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
